// File: rtl/pipe_front_ctrl.sv
// Pipeline front end: fetch PC, IF/ID and ID/EX registers with flush/stall
// steering, a small state tracker and saturating hazard event counters.
module pipe_front_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] NOP_INST = 32'h00000013,
   parameter int unsigned CTRL_W   = 16
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              pcWrite,
   input  logic              IF_ID_WE,
   input  logic              isNop,
   input  logic              br_taken,
   input  logic [31:0]       br_target,
   input  logic [31:0]       I_MEM_DI,
   input  logic [CTRL_W-1:0] ctrl_ID,
   input  logic [4:0]        rs1_ID,
   input  logic [4:0]        rs2_ID,
   input  logic [4:0]        rd_ID,
   output logic [31:0]       I_MEM_ADDR,
   output logic [31:0]       inst_ID,
   output logic [31:0]       pc_ID,
   output logic              valid_ID,
   output logic [CTRL_W-1:0] ctrl_EX,
   output logic [4:0]        rs1_EX,
   output logic [4:0]        rs2_EX,
   output logic [4:0]        rd_EX,
   output logic [31:0]       pc_EX,
   output logic              valid_EX,
   output logic [1:0]        state,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       inst_q, inst_d;
   logic [31:0]       pcid_q, pcid_d;
   logic              vid_q, vid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [4:0]        rs1_q, rs1_d;
   logic [4:0]        rs2_q, rs2_d;
   logic [4:0]        rd_q, rd_d;
   logic [31:0]       pcex_q, pcex_d;
   logic              vex_q, vex_d;
   logic [15:0]       scnt_q, scnt_d;
   logic [15:0]       fcnt_q, fcnt_d;

   logic              hazard;
   assign hazard = isNop | ~pcWrite;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      pcid_d  = pcid_q;
      vid_d   = vid_q;
      ctrl_d  = ctrl_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      pcex_d  = pcex_q;
      vex_d   = vex_q;
      scnt_d  = scnt_q;
      fcnt_d  = fcnt_q;

      if (br_taken) begin
         // Redirect wins over every hazard input; pc_ID is deliberately kept.
         state_d = ST_FLUSH;
         pc_d    = br_target;
         inst_d  = NOP_INST;
         vid_d   = 1'b0;
         ctrl_d  = '0;
         rs1_d   = '0;
         rs2_d   = '0;
         rd_d    = '0;
         pcex_d  = pcid_q;
         vex_d   = 1'b0;
         if (fcnt_q != '1) fcnt_d = fcnt_q + 16'd1;
      end else begin
         if (pcWrite) pc_d = pc_q + 32'd4;
         if (IF_ID_WE) begin
            inst_d = I_MEM_DI;
            pcid_d = pc_q;
            vid_d  = (state_q != ST_BOOT);
         end
         pcex_d = pcid_q;
         if (isNop) begin
            ctrl_d = '0;
            rs1_d  = '0;
            rs2_d  = '0;
            rd_d   = '0;
            vex_d  = 1'b0;
         end else begin
            ctrl_d = ctrl_ID;
            rs1_d  = rs1_ID;
            rs2_d  = rs2_ID;
            rd_d   = rd_ID;
            vex_d  = vid_q;
         end
         if (hazard && scnt_q != '1) scnt_d = scnt_q + 16'd1;
         if (state_q == ST_BOOT) state_d = ST_RUN;
         else if (hazard)        state_d = ST_STALL;
         else                    state_d = ST_RUN;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         pcid_q  <= '0;
         vid_q   <= 1'b0;
         ctrl_q  <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         pcex_q  <= '0;
         vex_q   <= 1'b0;
         scnt_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         pcid_q  <= pcid_d;
         vid_q   <= vid_d;
         ctrl_q  <= ctrl_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         pcex_q  <= pcex_d;
         vex_q   <= vex_d;
         scnt_q  <= scnt_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign I_MEM_ADDR = pc_q;
   assign inst_ID    = inst_q;
   assign pc_ID      = pcid_q;
   assign valid_ID   = vid_q;
   assign ctrl_EX    = ctrl_q;
   assign rs1_EX     = rs1_q;
   assign rs2_EX     = rs2_q;
   assign rd_EX      = rd_q;
   assign pc_EX      = pcex_q;
   assign valid_EX   = vex_q;
   assign state      = state_q;
   assign stall_cnt  = scnt_q;
   assign flush_cnt  = fcnt_q;

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Bench for pipe_front_ctrl: directed scenarios plus random hazards, compared
// each cycle against a behavioural model of the front end.
module tb_pipe_front_ctrl;

   logic        CLK, RSTn;
   logic        pcWrite, IF_ID_WE, isNop, br_taken;
   logic [31:0] br_target, I_MEM_DI;
   logic [15:0] ctrl_ID;
   logic [4:0]  rs1_ID, rs2_ID, rd_ID;
   logic [31:0] I_MEM_ADDR, inst_ID, pc_ID, pc_EX;
   logic        valid_ID, valid_EX;
   logic [15:0] ctrl_EX, stall_cnt, flush_cnt;
   logic [4:0]  rs1_EX, rs2_EX, rd_EX;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   localparam logic [31:0] NOP = 32'h00000013;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction

   assign I_MEM_DI = mem(I_MEM_ADDR);

   pipe_front_ctrl #(.RESET_PC(32'h00000000), .NOP_INST(NOP), .CTRL_W(16)) dut (
      .CLK(CLK), .RSTn(RSTn), .pcWrite(pcWrite), .IF_ID_WE(IF_ID_WE),
      .isNop(isNop), .br_taken(br_taken), .br_target(br_target),
      .I_MEM_DI(I_MEM_DI), .ctrl_ID(ctrl_ID), .rs1_ID(rs1_ID),
      .rs2_ID(rs2_ID), .rd_ID(rd_ID), .I_MEM_ADDR(I_MEM_ADDR),
      .inst_ID(inst_ID), .pc_ID(pc_ID), .valid_ID(valid_ID),
      .ctrl_EX(ctrl_EX), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
      .pc_EX(pc_EX), .valid_EX(valid_EX), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model of the architectural front-end state.
   logic [31:0] m_pc, m_inst, m_pcid, m_pcex;
   logic        m_vid, m_vex;
   logic [15:0] m_ctrl;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   int          m_state, m_scnt, m_fcnt;

   task automatic model_reset();
      m_pc = 0; m_inst = NOP; m_pcid = 0; m_vid = 0;
      m_ctrl = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_pcex = 0; m_vex = 0;
      m_state = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic model_edge();
      logic [31:0] opc, opcid;
      logic        ovid;
      int          ost;
      bit          hz;
      opc = m_pc; opcid = m_pcid; ovid = m_vid; ost = m_state;
      if (br_taken) begin
         m_pc = br_target; m_inst = NOP; m_vid = 0;
         m_ctrl = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_pcex = opcid; m_vex = 0;
         m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : 65535;
         m_state = 3;
      end else begin
         hz = isNop || !pcWrite;
         if (pcWrite) m_pc = opc + 32'd4;
         if (IF_ID_WE) begin
            m_inst = mem(opc); m_pcid = opc; m_vid = (ost != 0);
         end
         m_pcex = opcid;
         if (isNop) begin
            m_ctrl = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_vex = 0;
         end else begin
            m_ctrl = ctrl_ID; m_rs1 = rs1_ID; m_rs2 = rs2_ID; m_rd = rd_ID; m_vex = ovid;
         end
         if (hz) m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
         m_state = (ost == 0) ? 1 : (hz ? 2 : 1);
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLK or negedge RSTn);
         if (!RSTn) model_reset();
         else       model_edge();
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("addr", I_MEM_ADDR, m_pc);
         chk("inst_ID", inst_ID, m_inst);
         chk("pc_ID", pc_ID, m_pcid);
         chk("valid_ID", {31'd0, valid_ID}, {31'd0, m_vid});
         chk("ctrl_EX", {16'd0, ctrl_EX}, {16'd0, m_ctrl});
         chk("regs_EX", {17'd0, rs1_EX, rs2_EX, rd_EX}, {17'd0, m_rs1, m_rs2, m_rd});
         chk("pc_EX", pc_EX, m_pcex);
         chk("valid_EX", {31'd0, valid_EX}, {31'd0, m_vex});
         chk("state", {30'd0, state}, m_state);
         chk("stall_cnt", {16'd0, stall_cnt}, m_scnt);
         chk("flush_cnt", {16'd0, flush_cnt}, m_fcnt);
      end
   end

   task automatic cyc();
      ctrl_ID = 16'($urandom);
      rs1_ID  = 5'($urandom);
      rs2_ID  = 5'($urandom);
      rd_ID   = 5'($urandom);
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic no_hazard();
      pcWrite = 1; IF_ID_WE = 1; isNop = 0; br_taken = 0;
   endtask

   initial begin
      RSTn = 0; br_target = 0;
      no_hazard();
      ctrl_ID = 0; rs1_ID = 0; rs2_ID = 0; rd_ID = 0;
      repeat (3) @(negedge CLK);
      chk_en = 1;
      RSTn = 1;
      chk("lit_boot_addr", I_MEM_ADDR, 32'h0);
      chk("lit_boot_vid", {31'd0, valid_ID}, 32'd0);

      // Streaming fetch after reset release
      cyc();
      chk("lit_e1_addr", I_MEM_ADDR, 32'h4);
      chk("lit_e1_vid", {31'd0, valid_ID}, 32'd0);
      chk("lit_e1_state", {30'd0, state}, 32'd1);
      cyc();
      chk("lit_e2_addr", I_MEM_ADDR, 32'h8);
      chk("lit_e2_vid", {31'd0, valid_ID}, 32'd1);
      chk("lit_e2_vex", {31'd0, valid_EX}, 32'd0);
      cyc();
      chk("lit_e3_vex", {31'd0, valid_EX}, 32'd1);
      cyc();
      chk("lit_e4_addr", I_MEM_ADDR, 32'h10);

      // Load-use stall
      pcWrite = 0; IF_ID_WE = 0; isNop = 1;
      cyc();
      chk("lit_st_addr", I_MEM_ADDR, 32'h10);
      chk("lit_st_vex", {31'd0, valid_EX}, 32'd0);
      chk("lit_st_scnt", {16'd0, stall_cnt}, 32'd1);
      chk("lit_st_state", {30'd0, state}, 32'd2);
      no_hazard();
      cyc();
      chk("lit_st2_state", {30'd0, state}, 32'd1);
      chk("lit_st2_addr", I_MEM_ADDR, 32'h14);
      chk("lit_st2_pcex", pc_EX, 32'hC);
      chk("lit_st2_vex", {31'd0, valid_EX}, 32'd1);

      // Redirect concurrent with a stall request
      br_taken = 1; br_target = 32'h200; isNop = 1; pcWrite = 0;
      cyc();
      no_hazard();
      chk("lit_fl_addr", I_MEM_ADDR, 32'h200);
      chk("lit_fl_inst", inst_ID, NOP);
      chk("lit_fl_vid", {31'd0, valid_ID}, 32'd0);
      chk("lit_fl_vex", {31'd0, valid_EX}, 32'd0);
      chk("lit_fl_fcnt", {16'd0, flush_cnt}, 32'd1);
      chk("lit_fl_scnt", {16'd0, stall_cnt}, 32'd1);
      chk("lit_fl_state", {30'd0, state}, 32'd3);
      cyc();
      chk("lit_fl2_inst", inst_ID, mem(32'h200));
      chk("lit_fl2_pcid", pc_ID, 32'h200);
      chk("lit_fl2_vid", {31'd0, valid_ID}, 32'd1);

      // PC wrap-around
      br_taken = 1; br_target = 32'hFFFFFFFC;
      cyc();
      no_hazard();
      cyc();
      chk("lit_wrap_addr", I_MEM_ADDR, 32'h0);
      chk("lit_wrap_pcid", pc_ID, 32'hFFFFFFFC);

      // Random hazard mix
      for (int i = 0; i < 400; i++) begin
         br_taken  = ($urandom_range(0, 7) == 0);
         br_target = $urandom;
         isNop     = ($urandom_range(0, 3) == 0);
         pcWrite   = ($urandom_range(0, 3) != 0);
         IF_ID_WE  = ($urandom_range(0, 3) != 0);
         cyc();
      end

      // Stall counter saturation, then reset mid-stall
      no_hazard();
      pcWrite = 0;
      repeat (65537) cyc();
      chk("lit_sat_scnt", {16'd0, stall_cnt}, 32'h0000FFFF);
      #2 RSTn = 0;
      #1;
      chk("lit_rst_addr", I_MEM_ADDR, 32'h0);
      chk("lit_rst_inst", inst_ID, NOP);
      chk("lit_rst_pcid", pc_ID, 32'h0);
      chk("lit_rst_vid", {31'd0, valid_ID}, 32'd0);
      chk("lit_rst_ex", {ctrl_EX, 1'b0, rs1_EX, rs2_EX, rd_EX}, 32'h0);
      chk("lit_rst_pcex", pc_EX, 32'h0);
      chk("lit_rst_vex", {31'd0, valid_EX}, 32'd0);
      chk("lit_rst_state", {30'd0, state}, 32'd0);
      chk("lit_rst_cnt", {stall_cnt, flush_cnt}, 32'h0);
      @(negedge CLK);
      no_hazard();
      RSTn = 1;
      repeat (4) cyc();
      chk("lit_post_addr", I_MEM_ADDR, 32'h10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
